muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide sequencer for the RV32 core; implements MUL, MULHU, DIVU and REMU.
- Sits beside the single-cycle ALU. The decode stage raises start and holds the core stalled while busy=1.
- Uses one internal XLEN-bit adder/subtractor per iteration (radix-2 shift-add / restoring shift-subtract), so it adds little area.
- The result is written back to the register file in the cycle done=1.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request pulse; accepted only in IDLE.
- flush  input  1  aborts any operation in progress (pipeline kill).
- op  input  2  00=MUL (low word), 01=MULHU (high word, unsigned), 10=DIVU, 11=REMU.
- a  input  XLEN  rs1 operand; sampled only on the accept cycle.
- b  input  XLEN  rs2 operand; sampled only on the accept cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  XLEN  final value; held stable until the next accept.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal operand/accumulator registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and flush=0 -> latch a, b, op; clear accumulator; counter=0; go to RUN.
  - Any other input combination -> stay in IDLE.
- RUN: one iteration per cycle; counter increments; after XLEN iterations (counter reaches XLEN-1 and that iteration completes) go to DONE.
- Multiply (op 00/01):
  - Each iteration: if multiplier LSB=1, add multiplicand into the upper half of a 2*XLEN product register.
  - Then shift the product right by 1, keeping the adder carry-out.
  - MUL selects product[XLEN-1:0]; MULHU selects product[2*XLEN-1:XLEN].
- Divide (op 10/11), restoring division:
  - Each iteration: shift the {remainder, dividend} pair left by 1.
  - Trial-subtract the divisor. If there is no borrow, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (b=0), per the RISC-V spec:
  - DIVU result = all ones (32'hFFFFFFFF); REMU result = a.
  - Still takes the full XLEN iterations. No exception, no flag.
- DONE: done=1 and result updated this cycle; unconditionally return to IDLE next cycle.
- Latency: start accepted in cycle 0; RUN occupies cycles 1..XLEN; done=1 in cycle XLEN+1 (cycle 33 at default). The next accept is possible in cycle XLEN+2.
- Handshake and priority:
  - start while busy=1 is ignored, with no queueing.
  - Changes to a, b or op after the accept cycle have no effect.
- flush=1 in any state:
  - Next state is IDLE; done is not asserted (even if the current state is DONE, done is forced to 0 that cycle).
  - result keeps its previous value.
  - flush and start in the same cycle: flush wins and start is dropped.
- reset mid-operation: all registers return to reset values next edge; no done pulse.
- busy is combinational from state (RUN or DONE); done is combinational from state=DONE and flush=0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, an accepted multiply with a=0 or b=0 goes straight to DONE with result=0.
  - An accepted divide with b=0 goes straight to DONE with the divide-by-zero result.
  - Either case gives done in cycle 1, total latency 1.
  - All other operations are unchanged at XLEN+1.
- Undefined: every operation takes exactly XLEN+1 cycles; no zero-detect logic is synthesized.

Test Plan:
- Reset, then MUL a=7, b=6 -> busy=1 in cycles 1..33; done=1 only in cycle 33 with result=42; then busy=0, and result stays 42.
- MULHU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> result=32'hFFFFFFFE. Then MUL with the same operands -> result=32'h00000001.
- DIVU a=100, b=7 -> result=14. REMU a=100, b=7 -> result=2. DIVU a=5, b=0 -> 32'hFFFFFFFF in cycle 33 (cycle 1 with MULDIV_EARLY_OUT_EN). REMU a=5, b=0 -> 5.
- Start MUL 3*3, pulse start with MUL 9*9 at cycle 10, change a at cycle 5 -> both ignored; done at cycle 33 with result=9.
- Start DIVU 100/7, flush at cycle 20 -> busy=0 from cycle 21; no done pulse; result keeps the prior value. Then start and flush together -> stays in IDLE.
- Assert reset at cycle 15 of a MUL -> busy=0, done=0, result=0 the next cycle. A new MUL 2*3 then completes with result=6 at the normal latency.

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_seq : iterative radix-2 MUL/MULHU/DIVU/REMU sequencer, XLEN+1 cycles |
// | Option macro MULDIV_EARLY_OUT_EN: zero-operand shortcut to DONE.  Rev 1.0   |
// +----------------------------------------------------------------------------+
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_div;
  logic [XLEN:0]     add_x, add_y;
  logic [XLEN+1:0]   add_sum;
  logic              borrow;
  logic              early;
  logic [XLEN-1:0]   final_val;

  assign is_div = op_q[1];

`ifdef MULDIV_EARLY_OUT_EN
  assign early = op[1] ? (b == '0) : ((a == '0) || (b == '0));
`else
  assign early = 1'b0;
`endif

  // Shared adder: product-high + multiplicand, or {rem,next dividend bit} - divisor.
  always_comb begin
    if (is_div) begin
      add_x   = {hi_q, lo_q[XLEN-1]};
      add_y   = {1'b0, mcand_q};
      add_sum = {1'b0, add_x} - {1'b0, add_y};
    end else begin
      add_x   = {1'b0, hi_q};
      add_y   = lo_q[0] ? {1'b0, mcand_q} : '0;
      add_sum = {1'b0, add_x} + {1'b0, add_y};
    end
    borrow = add_sum[XLEN+1];
  end

  // Odd ops (MULHU, REMU) live in the high register, even ops in the low one.
  assign final_val = op_q[0] ? hi_q : lo_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d    = op;
            mcand_d = op[1] ? b : a;
            hi_d    = '0;
            lo_d    = op[1] ? a : b;
            cnt_d   = '0;
            state_d = S_RUN;
            if (early) begin
              // Preload registers so final_val yields 0, all-ones or a directly.
              hi_d    = op[1] ? a : '0;
              lo_d    = op[1] ? '1 : '0;
              state_d = S_DONE;
            end
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div) begin
            hi_d = borrow ? add_x[XLEN-1:0] : add_sum[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~borrow};
          end else begin
            hi_d = add_sum[XLEN:1];
            lo_d = {add_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          result_d = final_val;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !flush;
  assign result = done ? final_val : result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// Directed bench for muldiv_seq with an expected-result queue.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_for(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[1] ? (y == 0) : (x == 0 || y == 0)) return 1;
`endif
    return 33;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for done, compare latency/result; inject=1 pokes a at
  // cycle 5 and a second start at cycle 10, both of which must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit inject);
    int          lat;
    bit          busy_ok;
    logic [31:0] expv;
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    next_cycle();
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (lat <= 40) begin
      if (inject && lat == 5) a = 32'd77;
      if (inject && lat == 10) begin
        start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      next_cycle();
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(lat_for(o, x, y)));
    check({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
    check({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_result"}, result, expv);
    last_res = expv;
    next_cycle();
    @(negedge clk);
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    check({tag, "_done_after"}, {31'b0, done}, 32'd0);
    check({tag, "_result_held"}, result, last_res);
    next_cycle();
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
    last_res = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    next_cycle();

    run_op("mul_7x6", 2'd0, 32'd7, 32'd6, 1'b0);
    run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 1'b0);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);
    run_op("divu_5_0", 2'd2, 32'd5, 32'd0, 1'b0);
    run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 1'b0);
    run_op("mul_0x9", 2'd0, 32'd0, 32'd9, 1'b0);
    run_op("mulhu_mix", 2'd1, 32'h8765_4321, 32'h1234_5678, 1'b0);
    run_op("divu_big", 2'd2, 32'hFFFF_FFF0, 32'h0000_0013, 1'b0);
    run_op("remu_big", 2'd3, 32'hDEAD_BEEF, 32'h0001_0003, 1'b0);
    run_op("mul_3x3_ign", 2'd0, 32'd3, 32'd3, 1'b1);

    // Flush mid-RUN: no done, busy drops, result unchanged.
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    next_cycle();
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      next_cycle();
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_same", {31'b0, done}, 32'd0);
    check("flush_no_early_done", {31'b0, saw_done}, 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result", result, last_res);
    next_cycle();

    // start together with flush must not be accepted.
    start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd2; b = 32'd2;
    next_cycle();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("startflush_busy", {31'b0, busy}, 32'd0);
    check("startflush_result", result, last_res);
    next_cycle();

    // Flush during the DONE cycle suppresses done and the result update.
    start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 33; c++) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flushdone_busy", {31'b0, busy}, 32'd1);
    check("flushdone_done", {31'b0, done}, 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("flushdone_idle", {31'b0, busy}, 32'd0);
    check("flushdone_result", result, last_res);
    next_cycle();

    // Reset in the middle of a multiply.
    start = 1'b1; op = 2'd0; a = 32'd4; b = 32'd5;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 15; c++) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    next_cycle();
    last_res = '0;
    run_op("mul_2x3", 2'd0, 32'd2, 32'd3, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
